// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: takes a parallel word over valid/ready and shifts it
// onto a single idle-high line as start, LSB-first data, optional parity, stop.
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             tx,
  output logic             busy
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam bit HAS_PARITY = (PARITY != 0);
  localparam bit ODD_PARITY = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shiftReg;
  logic [BIT_W-1:0] r_bitCnt;
  logic [DIV_W-1:0] r_divCnt;
  logic             r_parityBit;
  logic             r_tx;
  logic             r_ready;
  logic             r_busy;

  state_t           w_stateNext;
  logic [WIDTH-1:0] w_shiftNext;
  logic [WIDTH-1:0] w_shifted;
  logic [BIT_W-1:0] w_bitNext;
  logic [DIV_W-1:0] w_divNext;
  logic             w_parityNext;
  logic             w_txNext;
  logic             w_readyNext;
  logic             w_bitEnd;
  logic             w_wordParity;

  assign w_bitEnd     = (r_divCnt == DIV_LAST);
  assign w_shifted    = r_shiftReg >> 1;
  assign w_wordParity = (^data_in) ^ ODD_PARITY;

  assign tx    = r_tx;
  assign ready = r_ready;
  assign busy  = r_busy;

  // State, datapath and registered outputs; reset abandons any partial frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shiftReg  <= '0;
      r_bitCnt    <= '0;
      r_divCnt    <= '0;
      r_parityBit <= 1'b0;
      r_tx        <= 1'b1;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_shiftReg  <= w_shiftNext;
      r_bitCnt    <= w_bitNext;
      r_divCnt    <= w_divNext;
      r_parityBit <= w_parityNext;
      r_tx        <= w_txNext;
      r_ready     <= w_readyNext;
      r_busy      <= ~w_readyNext;
    end
  end

  // Next state plus the line value for the coming cycle, so tx is registered
  // and changes on the very edge that enters each bit.
  always_comb begin
    w_stateNext  = r_state;
    w_shiftNext  = r_shiftReg;
    w_bitNext    = r_bitCnt;
    w_divNext    = r_divCnt;
    w_parityNext = r_parityBit;
    w_txNext     = r_tx;
    w_readyNext  = r_ready;

    case (r_state)
      ST_IDLE: begin
        w_divNext   = '0;
        w_bitNext   = '0;
        w_txNext    = 1'b1;
        w_readyNext = 1'b1;
        if (valid) begin
          w_stateNext  = ST_START;
          w_shiftNext  = data_in;
          w_parityNext = w_wordParity;
          w_txNext     = 1'b0;
          w_readyNext  = 1'b0;
        end
      end

      ST_START: begin
        if (w_bitEnd) begin
          w_divNext   = '0;
          w_stateNext = ST_DATA;
          w_txNext    = r_shiftReg[0];
        end else begin
          w_divNext = r_divCnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (w_bitEnd) begin
          w_divNext = '0;
          if (r_bitCnt == BIT_LAST) begin
            w_bitNext = '0;
            if (HAS_PARITY) begin
              w_stateNext = ST_PARITY;
              w_txNext    = r_parityBit;
            end else begin
              w_stateNext = ST_STOP;
              w_txNext    = 1'b1;
            end
          end else begin
            w_bitNext   = r_bitCnt + 1'b1;
            w_shiftNext = w_shifted;
            w_txNext    = w_shifted[0];
          end
        end else begin
          w_divNext = r_divCnt + 1'b1;
        end
      end

      ST_PARITY: begin
        if (w_bitEnd) begin
          w_divNext   = '0;
          w_stateNext = ST_STOP;
          w_txNext    = 1'b1;
        end else begin
          w_divNext = r_divCnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (w_bitEnd) begin
          w_divNext   = '0;
          w_stateNext = ST_IDLE;
          w_txNext    = 1'b1;
          w_readyNext = 1'b1;
        end else begin
          w_divNext = r_divCnt + 1'b1;
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
        w_divNext   = '0;
        w_bitNext   = '0;
        w_txNext    = 1'b1;
        w_readyNext = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: four differently parameterised instances share one
// stimulus stream and are checked every cycle against a frame-level model.
module tb_serial_frame_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid = 1'b0;
  logic [3:0] tx;
  logic [3:0] ready;
  logic [3:0] busy;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  int pW [4] = '{8, 8, 8, 5};
  int pC [4] = '{4, 4, 4, 1};
  int pP [4] = '{0, 1, 2, 2};

  bit active [4];
  int cyc [4];
  int word [4];
  bit expTx [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  bit expReady [4] = '{1'b1, 1'b1, 1'b1, 1'b1};

  logic recTx [4][128];
  logic recRdy [4][128];

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0)) dut0 (
    .clock(clock), .reset(reset), .data_in(data_in), .valid(valid),
    .ready(ready[0]), .tx(tx[0]), .busy(busy[0]));
  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1)) dut1 (
    .clock(clock), .reset(reset), .data_in(data_in), .valid(valid),
    .ready(ready[1]), .tx(tx[1]), .busy(busy[1]));
  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2)) dut2 (
    .clock(clock), .reset(reset), .data_in(data_in), .valid(valid),
    .ready(ready[2]), .tx(tx[2]), .busy(busy[2]));
  serial_frame_tx #(.WIDTH(5), .CLKS_PER_BIT(1), .PARITY(2)) dut3 (
    .clock(clock), .reset(reset), .data_in(data_in[4:0]), .valid(valid),
    .ready(ready[3]), .tx(tx[3]), .busy(busy[3]));

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clock = ~clock;

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int frameLen(int i);
    return (2 + pW[i] + ((pP[i] != 0) ? 1 : 0)) * pC[i];
  endfunction

  // Line bit b of a frame: 0 = start, 1..W = data LSB first, then parity, then stop.
  function automatic bit lineBit(int i, int w, int b);
    int par;
    if (b == 0) return 1'b0;
    if (b <= pW[i]) return ((w >> (b - 1)) & 1) != 0;
    if (pP[i] != 0 && b == pW[i] + 1) begin
      par = $countones(w) % 2;
      return (pP[i] == 2) ? (par == 0) : (par == 1);
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: on accept it fixes the word, then derives each cycle's
  // line value from the cycle index within the frame.
  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        active[i]   = 1'b0;
        cyc[i]      = 0;
        expTx[i]    = 1'b1;
        expReady[i] = 1'b1;
      end else if (active[i]) begin
        cyc[i]++;
        if (cyc[i] >= frameLen(i)) begin
          active[i]   = 1'b0;
          expTx[i]    = 1'b1;
          expReady[i] = 1'b1;
        end else begin
          expTx[i] = lineBit(i, word[i], cyc[i] / pC[i]);
        end
      end else if (expReady[i] && valid) begin
        active[i]   = 1'b1;
        cyc[i]      = 0;
        word[i]     = int'(data_in) & ((1 << pW[i]) - 1);
        expTx[i]    = 1'b0;
        expReady[i] = 1'b0;
      end
    end
  end

  // Every-cycle comparison of all instances against the model, away from the active edge.
  always @(negedge clock) begin
    if (checkEn) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("tx%0d", i), int'(tx[i]), int'(expTx[i]));
        checkOutput($sformatf("ready%0d", i), int'(ready[i]), int'(expReady[i]));
        checkOutput($sformatf("busy%0d", i), int'(busy[i]), int'(!expReady[i]));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    @(negedge clock);
    valid   = v;
    data_in = d;
  endtask

  // Records n cycles starting at the negedge after the accepting edge; after each
  // sample data_in takes dAfter, valid stays high only if hold, and a one-cycle
  // valid pulse carrying 8'hFF is issued at cycle pulseAt.
  task automatic recordCycles(input int n, input bit hold, input int pulseAt,
                              input logic [7:0] dAfter);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        recTx[i][k]  = tx[i];
        recRdy[i][k] = ready[i];
      end
      if (k == pulseAt) begin
        valid   = 1'b1;
        data_in = 8'hFF;
      end else begin
        valid   = hold;
        data_in = dAfter;
      end
    end
  endtask

  function automatic int lowCount(int i, int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (recRdy[i][k] == 1'b0) c++;
    return c;
  endfunction

  task automatic waitIdle();
    int n = 0;
    while (ready != 4'hF && n < 300) begin
      @(negedge clock);
      n++;
    end
    checkOutput("idleTimeout", int'(ready), 15);
  endtask

  initial begin
    logic [9:0] expA5;
    logic [7:0] expC3;
    logic [7:0] exp5A;
    expA5 = 10'b11_0100_1010;
    expC3 = 8'hC3;
    exp5A = 8'h5A;

    // Reset asserted between edges must force idle outputs immediately.
    #3 reset = 1'b1;
    #1;
    checkOutput("rstTx", int'(tx), 15);
    checkOutput("rstReady", int'(ready), 15);
    checkOutput("rstBusy", int'(busy), 0);
    @(negedge clock);
    reset   = 1'b0;
    checkEn = 1'b1;
    $display("[TB] reset checks done");

    // 8'hA5 without parity: line 0,1,0,1,0,0,1,0,1,1 and ready low 40 cycles.
    applyStimulus(1'b1, 8'hA5);
    recordCycles(48, 1'b0, -1, 8'h00);
    for (int j = 0; j < 10; j++)
      checkOutput($sformatf("A5bit%0d", j), int'(recTx[0][4*j+2]), int'(expA5[j]));
    checkOutput("A5readyLow", lowCount(0, 48), 40);
    checkOutput("A5readyBack", int'(recRdy[0][40]), 1);
    waitIdle();

    // 8'h07 with even/odd parity: parity bits 1 and 0, frames 44 cycles.
    applyStimulus(1'b1, 8'h07);
    recordCycles(48, 1'b0, -1, 8'h00);
    checkOutput("07evenPar", int'(recTx[1][38]), 1);
    checkOutput("07oddPar", int'(recTx[2][38]), 0);
    checkOutput("07evenLen", lowCount(1, 48), 44);
    checkOutput("07oddLen", lowCount(2, 48), 44);
    checkOutput("07narrowPar", int'(recTx[3][6]), 0);
    checkOutput("07narrowLen", lowCount(3, 48), 8);
    waitIdle();

    // valid held high: 8'h01 then 8'hFF with exactly one idle-high cycle between.
    applyStimulus(1'b1, 8'h01);
    recordCycles(96, 1'b1, -1, 8'hFF);
    applyStimulus(1'b0, 8'h00);
    checkOutput("b2bStop", int'(recTx[0][39]), 1);
    checkOutput("b2bIdleTx", int'(recTx[0][40]), 1);
    checkOutput("b2bIdleRdy", int'(recRdy[0][40]), 1);
    checkOutput("b2bStartTx", int'(recTx[0][41]), 0);
    checkOutput("b2bStartRdy", int'(recRdy[0][41]), 0);
    checkOutput("b2bSecondBit0", int'(recTx[0][47]), 1);
    waitIdle();

    // data_in changes after accept and a valid pulse while busy must not disturb 8'hC3.
    applyStimulus(1'b1, 8'hC3);
    recordCycles(48, 1'b0, 10, 8'h00);
    for (int j = 0; j < 8; j++)
      checkOutput($sformatf("C3bit%0d", j), int'(recTx[0][4*(j+1)+2]), int'(expC3[j]));
    checkOutput("C3pulseIgnored", int'(recTx[0][44]), 1);
    waitIdle();

    // Reset during data bit 3, then a clean 8'h5A frame.
    applyStimulus(1'b1, 8'h3C);
    recordCycles(18, 1'b0, -1, 8'h00);
    #1 reset = 1'b1;
    #1;
    checkOutput("midRstTx", int'(tx), 15);
    checkOutput("midRstReady", int'(ready), 15);
    checkOutput("midRstBusy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b1, 8'h5A);
    recordCycles(48, 1'b0, -1, 8'h00);
    checkOutput("5Astart", int'(recTx[0][2]), 0);
    for (int j = 0; j < 8; j++)
      checkOutput($sformatf("5Abit%0d", j), int'(recTx[0][4*(j+1)+2]), int'(exp5A[j]));
    checkOutput("5Astop", int'(recTx[0][38]), 1);
    checkOutput("5AreadyLow", lowCount(0, 48), 40);
    waitIdle();

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clock);
      if ($urandom_range(0, 199) == 0) begin
        valid = 1'b0;
        #1 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end else begin
        valid   = ($urandom_range(0, 2) != 0);
        data_in = 8'($urandom);
      end
    end
    valid = 1'b0;
    waitIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
